// File: rtl/pq_ctrl.sv
// Front-end controller that turns producer/consumer valid-ready streams into priQueue load/shift/clear strobes.
// Latency: a push at edge N is visible on out_data from cycle N+1; strobes are combinational in the handshake cycle.
// Backpressure: in_ready drops when full, on a pop, on flush, or outside RUN; pop wins over push in a shared cycle.
module pq_ctrl #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             ck,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             drain,
    output logic [WIDTH-1:0] q_newVal,
    output logic             q_loadIn,
    output logic             q_shiftOut,
    output logic             q_clear,
    input  logic [WIDTH-1:0] q_top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q,  full_d;
    logic             empty_q, empty_d;

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_upd;

    // Data path is a straight pass-through: the queue holds the values, this block only steers it.
    assign q_newVal = in_data;
    assign out_data = q_top;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;

    // Handshake decode. Reset gates the ready/strobe outputs so nothing moves while the queue is held in reset.
    // A flush request suppresses both push and pop in its own cycle so the queue sees only the clear.
    always_comb begin
        out_valid  = 1'b0;
        pop        = 1'b0;
        in_ready   = 1'b0;
        push       = 1'b0;
        q_clear    = 1'b0;

        out_valid  = !r && !empty_q && (state_q != ST_CLEAR);
        pop        = out_valid && out_ready && !flush;
        in_ready   = !r && (state_q == ST_RUN) && !full_q && !pop && !flush;
        push       = in_valid && in_ready;
        q_clear    = !r && (state_q == ST_CLEAR);
    end

    assign q_loadIn   = push;
    assign q_shiftOut = pop;

    // Occupancy after this cycle's handshake; push and pop are mutually exclusive by construction.
    always_comb begin
        count_upd = count_q;
        if (push && (count_q != CNT_MAX)) begin
            count_upd = count_q + CNT_ONE;
        end else if (pop && (count_q != CNT_ZERO)) begin
            count_upd = count_q - CNT_ONE;
        end
    end

    // Next-state and next-occupancy: flush zeroes the count on the edge entering CLEAR,
    // and the CLEAR cycle itself drives the queue clear strobe.
    always_comb begin
        state_d = state_q;
        count_d = count_q;

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_CLEAR;
                    count_d = CNT_ZERO;
                end else begin
                    count_d = count_upd;
                    // A drain that empties the queue in the same cycle has nothing left to wait for.
                    if (drain && (count_upd != CNT_ZERO)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
                count_d = CNT_ZERO;
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_CLEAR;
                    count_d = CNT_ZERO;
                end else begin
                    count_d = count_upd;
                    if (count_upd == CNT_ZERO) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                count_d = CNT_ZERO;
            end
        endcase
    end

    // Status flags are registered from the next count so they line up with count_q.
    always_comb begin
        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == CNT_ZERO);
    end

    // State register; the same asynchronous reset also clears the downstream queue.
    always_ff @(posedge ck or posedge r) begin
        if (r) begin
            state_q <= ST_RUN;
            count_q <= CNT_ZERO;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Invariants: the queue can never load and shift together, and occupancy stays within bounds.
    property p_no_load_and_shift;
        @(posedge ck) disable iff (r) !(q_loadIn && q_shiftOut);
    endproperty
    a_no_load_and_shift: assert property (p_no_load_and_shift);

    property p_count_bounded;
        @(posedge ck) disable iff (r) (count_q <= CNT_MAX);
    endproperty
    a_count_bounded: assert property (p_count_bounded);

endmodule
